// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing (pixel divider, X/Y counters, sync/blank decode).
// All outputs are registers. Sync and blank are decoded from the counters' next
// value, so they change on the same edge as the counters and always describe
// the counter values currently on the outputs.
// Optional feature (macro VGA_FRAME_COUNT_EN): adds the 16-bit frame counter
// output frame_cnt, which is used for blink and animation of letters.
`timescale 1ns/1ps
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter int SYNC_POL = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        pix_en,
    output logic        vga_clk,
    output logic [12:0] counterX,
    output logic [12:0] counterY,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        active,
`ifdef VGA_FRAME_COUNT_EN
    output logic        frame_start,
    output logic [15:0] frame_cnt
`else
    output logic        frame_start
`endif
);

    localparam logic [12:0] H_LAST   = 13'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [12:0] V_LAST   = 13'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [12:0] H_VIS    = 13'(H_ACTIVE);
    localparam logic [12:0] V_VIS    = 13'(V_ACTIVE);
    localparam logic [12:0] HS_START = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] VS_START = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        SYNC_ACT = (SYNC_POL != 0) ? 1'b1 : 1'b0;

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic            DIV_BYPASS = (CLK_DIV <= 1) ? 1'b1 : 1'b0;

    logic [DIV_W-1:0] div_q,    div_d;
    logic             pix_en_q, pix_en_d;
    logic             vga_clk_q, vga_clk_d;
    logic [12:0]      x_q,      x_d;
    logic [12:0]      y_q,      y_d;
    logic             hsync_q,  hsync_d;
    logic             vsync_q,  vsync_d;
    logic             blank_n_q, blank_n_d;
    logic             frame_start_q, frame_start_d;
    logic             x_end_s;
    logic             y_end_s;

    assign x_end_s = (x_q == H_LAST);
    assign y_end_s = (y_q == V_LAST);

    // Pixel divider: next divider phase, pixel-enable and DAC pixel clock.
    // pix_en is registered so it reads 0 during reset even when CLK_DIV is 1.
    always_comb begin
        div_d     = div_q;
        pix_en_d  = 1'b0;
        vga_clk_d = 1'b0;
        if (div_q == DIV_LAST) begin
            div_d = {DIV_W{1'b0}};
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        pix_en_d = (div_d == DIV_LAST);
        if (DIV_BYPASS) begin
            vga_clk_d = 1'b1;
        end else begin
            vga_clk_d = (div_d >= DIV_HALF);
        end
    end

    // Raster counters: advance on pix_en, wrapping X at line end and Y at frame end.
    always_comb begin
        x_d           = x_q;
        y_d           = y_q;
        frame_start_d = 1'b0;
        if (pix_en_q) begin
            if (x_end_s) begin
                x_d = 13'd0;
                if (y_end_s) begin
                    y_d           = 13'd0;
                    frame_start_d = 1'b1;
                end else begin
                    y_d = y_q + 13'd1;
                end
            end else begin
                x_d = x_q + 13'd1;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Sync/blank decode from the next counter values (zero skew to the counters).
    always_comb begin
        hsync_d   = ~SYNC_ACT;
        vsync_d   = ~SYNC_ACT;
        blank_n_d = 1'b0;
        if ((x_d >= HS_START) && (x_d < HS_END)) begin
            hsync_d = SYNC_ACT;
        end else begin
            hsync_d = ~SYNC_ACT;
        end
        if ((y_d >= VS_START) && (y_d < VS_END)) begin
            vsync_d = SYNC_ACT;
        end else begin
            vsync_d = ~SYNC_ACT;
        end
        blank_n_d = (x_d < H_VIS) && (y_d < V_VIS);
    end

    // Timing state registers with asynchronous reset to the idle raster state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q         <= {DIV_W{1'b0}};
            pix_en_q      <= 1'b0;
            vga_clk_q     <= 1'b0;
            x_q           <= 13'd0;
            y_q           <= 13'd0;
            hsync_q       <= ~SYNC_ACT;
            vsync_q       <= ~SYNC_ACT;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_en_q      <= pix_en_d;
            vga_clk_q     <= vga_clk_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_n_q     <= blank_n_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    // Frame counter: counts cycles in which frame_start is high, wrapping naturally.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign pix_en      = pix_en_q;
    assign vga_clk     = vga_clk_q;
    assign counterX    = x_q;
    assign counterY    = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank_n     = blank_n_q;
    assign active      = blank_n_q;
    assign frame_start = frame_start_q;

endmodule
